// File: rtl/param_sync_fifo.sv
// -----------------------------------------------------------------------------
// param_sync_fifo
//
// Single-clock FIFO with a parameterised width and depth, occupancy flags,
// sticky error flags and a selectable read mode.
//
// Parameters
//   DATA_W    data width in bits
//   DEPTH     number of entries; must be a power of two and at least 4
//   AF_LEVEL  almost_full asserts when count >= AF_LEVEL
//   AE_LEVEL  almost_empty asserts when count <= AE_LEVEL
//   FWFT      0: registered read, where rd_data/valid appear one cycle after
//                an accepted rd_en
//             1: first-word-fall-through, where the head entry is shown
//                combinationally and valid = ~empty
//
// Ports
//   clk           rising-edge clock for all state
//   rst           asynchronous, active-low reset
//   wr_en/wr_data write request and its data
//   rd_en         read (pop) request
//   clr_err       clears overflow/underflow; a new error in the same cycle wins
//   rd_data       read data, qualified by valid
//   valid         rd_data qualifier
//   empty, full, almost_full, almost_empty
//                 occupancy flags, decoded from the registered count
//   count         current occupancy, 0..DEPTH
//   overflow      sticky: a write was refused because the FIFO was full
//   underflow     sticky: a read was refused because the FIFO was empty
//
// Handshake semantics
//   wr_en and rd_en are requests, and no ready signal is returned. A write is
//   accepted when wr_en=1 and either full=0 or a read is accepted in the same
//   cycle. A read is accepted when rd_en=1 and empty=0. A request that is not
//   accepted changes no storage or pointer, and it sets the matching sticky
//   error flag. Writes never bypass to the read side: a write and a read on an
//   empty FIFO store the write and refuse the read.
// -----------------------------------------------------------------------------
module param_sync_fifo #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic                     clr_err,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     valid,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  // Address bits, and the width of pointers and count (one extra wrap bit).
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];

  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic          underflow_q;

  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  logic wr_acc;
  logic rd_acc;
  logic wr_rej;
  logic rd_rej;

  // The pointer wrap bits are kept so the pointers read naturally in a
  // waveform. Occupancy comes from count_q, so the wrap bits feed nothing.
  logic unused_ptr_msb;
  assign unused_ptr_msb = wr_ptr[AW] ^ rd_ptr[AW];

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];

  // ---------------------------------------------------------------------------
  // Flags: decoded only from the registered count
  // ---------------------------------------------------------------------------
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_C);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // ---------------------------------------------------------------------------
  // Acceptance
  // ---------------------------------------------------------------------------
  // A read can only be accepted from a non-empty FIFO. When the FIFO is full,
  // an accepted read frees the slot the write lands in on the same edge. The
  // old head is read before the new data overwrites it.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);
  assign wr_rej = wr_en & ~wr_acc;
  assign rd_rej = rd_en & ~rd_acc;

  // ---------------------------------------------------------------------------
  // Storage (not reset; a reset simply discards entries by clearing pointers)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers and occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ONE_C;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ONE_C;
      end
      // Simultaneous write and read leaves occupancy unchanged.
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + ONE_C;
        2'b01:   count_q <= count_q - ONE_C;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags: a new error in the same cycle as clr_err keeps the
  // flag set, so no event is ever lost to a clear.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_rej) begin
        overflow_q <= 1'b1;
      end else if (clr_err) begin
        overflow_q <= 1'b0;
      end

      if (rd_rej) begin
        underflow_q <= 1'b1;
      end else if (clr_err) begin
        underflow_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read port
  // ---------------------------------------------------------------------------
  if (FWFT == 0) begin : g_std_read
    // Registered read: the head is captured on the accepting edge, and valid
    // is high for exactly the following cycle. rd_data holds otherwise.
    logic [DATA_W-1:0] rd_data_q;
    logic              valid_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rd_data_q <= '0;
        valid_q   <= 1'b0;
      end else begin
        valid_q <= rd_acc;
        if (rd_acc) begin
          rd_data_q <= mem[rd_idx];
        end
      end
    end

    assign rd_data = rd_data_q;
    assign valid   = valid_q;
  end else begin : g_fwft_read
    // Fall-through: the head entry is always on rd_data, and rd_en pops it.
    // The output is forced to zero while empty, so reset and empty states
    // present a defined value instead of stale or uninitialised memory.
    assign valid   = ~empty;
    assign rd_data = empty ? '0 : mem[rd_idx];
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_param_sync_fifo
//
// Bench for param_sync_fifo. Two instances share clock and reset:
//   dut0: registered read (FWFT=0), checked by a scoreboard
//   dut1: fall-through read (FWFT=1), checked with directed vectors
// -----------------------------------------------------------------------------
module tb_param_sync_fifo;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic        wr_en0, rd_en0, clr_err0;
  logic [31:0] wr_data0, rd_data0;
  logic        valid0, empty0, full0, af0, ae0, ovf0, unf0;
  logic [4:0]  count0;

  logic        wr_en1, rd_en1, clr_err1;
  logic [31:0] wr_data1, rd_data1;
  logic        valid1, empty1, full1, af1, ae1, ovf1, unf1;
  logic [4:0]  count1;

  param_sync_fifo #(
    .DATA_W(32), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)
  ) dut0 (
    .clk(clk), .rst(rst),
    .wr_en(wr_en0), .wr_data(wr_data0), .rd_en(rd_en0), .clr_err(clr_err0),
    .rd_data(rd_data0), .valid(valid0),
    .empty(empty0), .full(full0), .almost_full(af0), .almost_empty(ae0),
    .count(count0), .overflow(ovf0), .underflow(unf0)
  );

  param_sync_fifo #(
    .DATA_W(32), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)
  ) dut1 (
    .clk(clk), .rst(rst),
    .wr_en(wr_en1), .wr_data(wr_data1), .rd_en(rd_en1), .clr_err(clr_err1),
    .rd_data(rd_data1), .valid(valid1),
    .empty(empty1), .full(full1), .almost_full(af1), .almost_empty(ae1),
    .count(count1), .overflow(ovf1), .underflow(unf1)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          n_total;
  int          n_pass;
  logic [31:0] exp_q[$];   // expected rd_data values, in order
  logic [31:0] m_q[$];     // model of FIFO contents
  int          m_count;
  logic        m_ovf;
  logic        m_unf;
  logic        exp_valid;
  logic        mon_en;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Driver: applies one cycle of requests to dut0 and updates the model.
  // ---------------------------------------------------------------------------
  task automatic step(input logic w, input logic [31:0] d, input logic r,
                      input logic c);
    logic rd_ok;
    logic wr_ok;
    wr_en0   = w;
    wr_data0 = d;
    rd_en0   = r;
    clr_err0 = c;
    rd_ok = r && (m_count > 0);
    wr_ok = w && ((m_count < 16) || rd_ok);
    if (rd_ok) exp_q.push_back(m_q.pop_front());
    if (wr_ok) m_q.push_back(d);
    @(posedge clk);
    #1;
    m_count   = m_q.size();
    m_ovf     = (w && !wr_ok) ? 1'b1 : (c ? 1'b0 : m_ovf);
    m_unf     = (r && !rd_ok) ? 1'b1 : (c ? 1'b0 : m_unf);
    exp_valid = rd_ok;
    wr_en0    = 1'b0;
    rd_en0    = 1'b0;
    clr_err0  = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: mid-cycle compare of dut0 against the model
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (mon_en) begin
      check("valid", valid0, exp_valid);
      if (valid0) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_valid: got rd_data 0x%0h expected no output", rd_data0);
        end else begin
          check("rd_data", rd_data0, exp_q.pop_front());
        end
      end
      check("count", count0, m_count);
      check("empty", empty0, m_count == 0);
      check("full", full0, m_count == 16);
      check("almost_full", af0, m_count >= 14);
      check("almost_empty", ae0, m_count <= 2);
      check("overflow", ovf0, m_ovf);
      check("underflow", unf0, m_unf);
    end
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b0;
    wr_en0 = 0; rd_en0 = 0; clr_err0 = 0; wr_data0 = '0;
    wr_en1 = 0; rd_en1 = 0; clr_err1 = 0; wr_data1 = '0;
    n_total = 0; n_pass = 0;
    m_count = 0; m_ovf = 0; m_unf = 0; exp_valid = 0; mon_en = 0;

    // Reset values
    #12;
    check("rst_count", count0, 0);
    check("rst_empty", empty0, 1);
    check("rst_ae", ae0, 1);
    check("rst_full", full0, 0);
    check("rst_af", af0, 0);
    check("rst_valid", valid0, 0);
    check("rst_rd_data", rd_data0, 0);
    check("rst_ovf", ovf0, 0);
    check("rst_unf", unf0, 0);
    check("rst_fwft_valid", valid1, 0);
    check("rst_fwft_rd_data", rd_data1, 0);

    @(negedge clk);
    rst = 1'b1;
    #1;
    mon_en = 1'b1;

    // Fill with 0..15, then drain in order
    for (int i = 0; i < 16; i++) begin
      step(1, i, 0, 0);
      if (i == 12) check("af_at_13", af0, 0);
      if (i == 13) begin
        check("af_at_14", af0, 1);
        check("not_full_at_14", full0, 0);
      end
    end
    check("count_16", count0, 16);
    check("full_at_16", full0, 1);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, 0);
      check("fill_drain_data", rd_data0, i);
    end
    step(0, 0, 0, 0);
    check("fill_drain_empty", empty0, 1);

    // Overflow on a full FIFO; 0xDEAD must never come out
    for (int i = 0; i < 16; i++) step(1, 32'h100 + i, 0, 0);
    step(1, 32'hDEAD, 0, 0);
    check("ovf_set", ovf0, 1);
    check("ovf_count", count0, 16);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, 0);
      check("ovf_drain_data", rd_data0, 32'h100 + i);
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    check("ovf_cleared", ovf0, 0);

    // Set wins over clear
    step(0, 0, 1, 0);
    check("unf_set", unf0, 1);
    step(0, 0, 1, 1);
    check("unf_set_wins", unf0, 1);
    step(0, 0, 0, 1);
    check("unf_cleared", unf0, 0);

    // Write and read together on an empty FIFO: no bypass
    step(1, 32'h55, 1, 0);
    check("empty_wr_rd_count", count0, 1);
    check("empty_wr_rd_unf", unf0, 1);
    check("empty_wr_rd_no_valid", valid0, 0);
    step(0, 0, 1, 0);
    check("empty_wr_rd_data", rd_data0, 32'h55);
    check("empty_wr_rd_valid", valid0, 1);
    step(0, 0, 0, 0);
    check("rd_data_hold", rd_data0, 32'h55);
    step(0, 0, 0, 1);

    // Full FIFO, write and read together for 20 cycles across the wrap
    for (int i = 0; i < 16; i++) step(1, 32'h300 + i, 0, 0);
    for (int k = 0; k < 20; k++) step(1, 32'h400 + k, 1, 0);
    check("full_rw_count", count0, 16);
    check("full_rw_no_ovf", ovf0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0);
    check("full_rw_last", rd_data0, 32'h413);
    step(0, 0, 0, 0);

    // Asynchronous reset with 9 entries stored
    for (int i = 0; i < 9; i++) step(1, 32'h500 + i, 0, 0);
    #2;
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    check("arst_count", count0, 0);
    check("arst_empty", empty0, 1);
    check("arst_ae", ae0, 1);
    check("arst_full", full0, 0);
    check("arst_af", af0, 0);
    check("arst_valid", valid0, 0);
    check("arst_rd_data", rd_data0, 0);
    check("arst_ovf", ovf0, 0);
    check("arst_unf", unf0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    m_q.delete();
    exp_q.delete();
    m_count = 0; m_ovf = 0; m_unf = 0; exp_valid = 0;
    #1;
    mon_en = 1'b1;
    step(0, 0, 1, 0);
    check("post_rst_unf", unf0, 1);
    check("post_rst_no_valid", valid0, 0);
    step(0, 0, 0, 0);
    check("sb_drained", exp_q.size(), 0);

    // Fall-through instance
    @(posedge clk); #1;
    wr_en1 = 1; wr_data1 = 32'hA5;
    @(posedge clk); #1;
    wr_en1 = 0;
    check("fwft_valid", valid1, 1);
    check("fwft_data", rd_data1, 32'hA5);
    @(posedge clk); #1;
    check("fwft_hold_valid", valid1, 1);
    check("fwft_hold_data", rd_data1, 32'hA5);
    rd_en1 = 1;
    @(posedge clk); #1;
    rd_en1 = 0;
    check("fwft_pop_valid", valid1, 0);
    check("fwft_pop_empty", empty1, 1);
    wr_en1 = 1; wr_data1 = 32'h11;
    @(posedge clk); #1;
    wr_data1 = 32'h22;
    @(posedge clk); #1;
    wr_en1 = 0;
    check("fwft_head1", rd_data1, 32'h11);
    check("fwft_count2", count1, 2);
    rd_en1 = 1;
    @(posedge clk); #1;
    check("fwft_head2", rd_data1, 32'h22);
    @(posedge clk); #1;
    check("fwft_unf_clear", unf1, 0);
    check("fwft_drained", empty1, 1);
    @(posedge clk); #1;
    rd_en1 = 0;
    check("fwft_unf", unf1, 1);
    check("fwft_ovf", ovf1, 0);
    check("fwft_full", full1, 0);
    check("fwft_af", af1, 0);
    check("fwft_ae", ae1, 1);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the data width in bits.
REQ-002 Parameter DEPTH, default 16, SHALL set the entry count, and SHALL be a power of two and at least 4.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, SHALL set the almost_full threshold in entries.
REQ-004 Parameter AE_LEVEL, default 2, SHALL set the almost_empty threshold in entries.
REQ-005 Parameter FWFT, default 0, SHALL select the read mode: 0 = standard registered read, 1 = first-word-fall-through.
REQ-006 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-007 rst  in  1  reset, asynchronous assert, active-low.
REQ-008 wr_en  in  1  write request.
REQ-009 wr_data  in  DATA_W  write data.
REQ-010 rd_en  in  1  read/pop request.
REQ-011 clr_err  in  1  clears the sticky error flags.
REQ-012 rd_data  out  DATA_W  read data.
REQ-013 valid  out  1  rd_data qualifier.
REQ-014 empty, full, almost_full, almost_empty  out  1 each  occupancy flags.
REQ-015 count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-016 overflow, underflow  out  1 each  sticky error flags.

Function
REQ-017 Storage SHALL be a DEPTH x DATA_W array addressed by write and read pointers, each $clog2(DEPTH)+1 bits wide, using the MSB as a wrap bit; pointers SHALL wrap from DEPTH-1 to 0 in the low bits.
REQ-018 A write SHALL be accepted when wr_en=1 and (full=0 or an accepted read occurs in the same cycle); an accepted write SHALL store wr_data and increment the write pointer.
REQ-019 A read SHALL be accepted when rd_en=1 and empty=0; an accepted read SHALL increment the read pointer.
REQ-020 count SHALL be a register updated as follows: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-021 Flags SHALL be decoded only from registered count: empty = (count==0), full = (count==DEPTH), almost_full = (count>=AF_LEVEL), almost_empty = (count<=AE_LEVEL).
REQ-022 When FWFT=0, an accepted read SHALL register the head entry into rd_data and assert valid for exactly the next cycle (latency 1); rd_data SHALL hold its value otherwise.
REQ-023 When FWFT=1, valid SHALL equal ~empty and rd_data SHALL present the head entry combinationally; rd_en SHALL pop the head.
REQ-024 With full=1, simultaneous wr_en and rd_en SHALL both be accepted and count SHALL stay at DEPTH.
REQ-025 With empty=1, simultaneous wr_en and rd_en SHALL accept the write only; the read SHALL be rejected and underflow SHALL be set. There SHALL be no bypass path.
REQ-026 A rejected write (wr_en=1, full=1, no accepted read) SHALL leave memory and pointers unchanged and set overflow.
REQ-027 A rejected read SHALL leave pointers unchanged, SHALL keep valid=0 in FWFT=0 mode, and SHALL set underflow.
REQ-028 overflow and underflow SHALL remain set until a cycle with clr_err=1; if a new error occurs in the same cycle as clr_err, set SHALL win.

Reset
REQ-029 While rst=0, the block SHALL drive: pointers 0, count 0, empty 1, almost_empty 1, full 0, almost_full 0, valid 0, rd_data 0, overflow 0, underflow 0.
REQ-030 Memory contents SHALL NOT be reset; an assertion of rst in mid-operation SHALL discard all stored entries.
REQ-031 After rst deasserts, requests SHALL be honoured from the first rising edge.

Verification (DATA_W=32, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2)
REQ-032 Write 0x0..0xF on 16 cycles, then read 16 -> count reaches 16, full=1 and almost_full=1 at count 14, rd_data 0x0..0xF in order with valid one cycle after each rd_en (FWFT=0).
REQ-033 Full FIFO, wr_en=1 with data 0xDEAD -> overflow=1, count=16, the next 16 reads return no 0xDEAD; clr_err pulse -> overflow=0.
REQ-034 Empty FIFO, wr_en=1 and rd_en=1 with data 0x55 -> count=1, underflow=1, the next read returns 0x55.
REQ-035 Full FIFO, wr_en=1 and rd_en=1 for 20 cycles with an incrementing pattern -> count stays 16, no overflow, output order preserved across pointer wrap.
REQ-036 FWFT=1: write 0xA5 -> on the next cycle valid=1 and rd_data=0xA5 with no rd_en; rd_en pop -> valid=0 and empty=1.
REQ-037 Assert rst with 9 entries stored -> all outputs take the REQ-029 values immediately without waiting for clk; after release, reads are rejected and underflow=1.
